// File: rtl/adder_result_checker.sv
`default_nettype none
// ============================================================================
// Module      : adder_result_checker
// Description : Response checker for a WIDTH-bit adder. It delays each operand
//               set by LAT cycles, compares the adder's {carry,sum} with
//               a+b+cin, and keeps saturating pass/error counts and a snapshot
//               of the first failing vector.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_result_checker #(
    parameter int WIDTH = 4,
    parameter int LAT   = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    input  logic [WIDTH-1:0] sum,
    input  logic             carry,
    output logic             chk_valid,
    output logic             mismatch,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_flag,
    output logic [WIDTH-1:0] first_err_a,
    output logic [WIDTH-1:0] first_err_b,
    output logic             first_err_cin,
    output logic [WIDTH:0]   first_err_exp,
    output logic [WIDTH:0]   first_err_got
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic             w_cmp_valid;
    logic [WIDTH-1:0] w_cmp_a;
    logic [WIDTH-1:0] w_cmp_b;
    logic             w_cmp_cin;
    logic [WIDTH:0]   w_exp;
    logic [WIDTH:0]   w_got;
    logic             w_match;

    generate
        if (LAT < 0 || LAT > 7) begin : g_lat_range_err
            $error("adder_result_checker: LAT must be in 0..7");
        end

        if (LAT == 0) begin : g_no_delay
            assign w_cmp_valid = valid_in;
            assign w_cmp_a     = a_in;
            assign w_cmp_b     = b_in;
            assign w_cmp_cin   = c_in;
        end else begin : g_delay
            logic             r_dv [LAT];
            logic [WIDTH-1:0] r_da [LAT];
            logic [WIDTH-1:0] r_db [LAT];
            logic             r_dc [LAT];

            // Data stages shift freely; only the valids are flushed by clear.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < LAT; i++) begin
                        r_dv[i] <= 1'b0;
                        r_da[i] <= '0;
                        r_db[i] <= '0;
                        r_dc[i] <= 1'b0;
                    end
                end else begin
                    r_dv[0] <= valid_in & ~clear;
                    r_da[0] <= a_in;
                    r_db[0] <= b_in;
                    r_dc[0] <= c_in;
                    for (int i = 1; i < LAT; i++) begin
                        r_dv[i] <= r_dv[i-1] & ~clear;
                        r_da[i] <= r_da[i-1];
                        r_db[i] <= r_db[i-1];
                        r_dc[i] <= r_dc[i-1];
                    end
                end
            end

            assign w_cmp_valid = r_dv[LAT-1];
            assign w_cmp_a     = r_da[LAT-1];
            assign w_cmp_b     = r_db[LAT-1];
            assign w_cmp_cin   = r_dc[LAT-1];
        end
    endgenerate

    assign w_exp   = {1'b0, w_cmp_a} + {1'b0, w_cmp_b} + {{WIDTH{1'b0}}, w_cmp_cin};
    assign w_got   = {carry, sum};
    // Case equality so that an X/Z result from the adder is reported as a failure.
    assign w_match = (w_got === w_exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_valid     <= 1'b0;
            mismatch      <= 1'b0;
            pass_cnt      <= '0;
            err_cnt       <= '0;
            err_flag      <= 1'b0;
            first_err_a   <= '0;
            first_err_b   <= '0;
            first_err_cin <= 1'b0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else if (clear) begin
            chk_valid     <= 1'b0;
            mismatch      <= 1'b0;
            pass_cnt      <= '0;
            err_cnt       <= '0;
            err_flag      <= 1'b0;
            first_err_a   <= '0;
            first_err_b   <= '0;
            first_err_cin <= 1'b0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else begin
            chk_valid <= w_cmp_valid;
            mismatch  <= w_cmp_valid & ~w_match;
            if (w_cmp_valid) begin
                if (w_match) begin
                    if (pass_cnt != c_cnt_max) begin
                        pass_cnt <= pass_cnt + 1'b1;
                    end
                end else begin
                    if (err_cnt != c_cnt_max) begin
                        err_cnt <= err_cnt + 1'b1;
                    end
                    err_flag <= 1'b1;
                    if (!err_flag) begin
                        first_err_a   <= w_cmp_a;
                        first_err_b   <= w_cmp_b;
                        first_err_cin <= w_cmp_cin;
                        first_err_exp <= w_exp;
                        first_err_got <= w_got;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder_result_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_result_checker
// Description : Bench for adder_result_checker at LAT=0, LAT=2 and LAT=3/CNT_W=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_result_checker;

    typedef struct {
        int due;
        int k;
        int a;
        int b;
        int cin;
        int mask;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       valid_in;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [4:0] mask;

    logic [4:0] live;
    logic [4:0] hist [0:7];
    logic [3:0] sum0, sum1, sum2;
    logic       carry0, carry1, carry2;

    logic        cv0, mm0, fl0, fc0;
    logic        cv1, mm1, fl1, fc1;
    logic        cv2, mm2, fl2, fc2;
    logic [15:0] pc0, ec0, pc1, ec1;
    logic [3:0]  pc2, ec2;
    logic [3:0]  fa0, fb0, fa1, fb1, fa2, fb2;
    logic [4:0]  fe0, fg0, fe1, fg1, fe2, fg2;

    int   LATS [3] = '{0, 2, 3};
    int   CMAX [3] = '{65535, 65535, 15};
    vec_t q[$];
    int   cyc;
    int   m_cv [3], m_mm [3], m_pc [3], m_ec [3], m_fl [3];
    int   m_fa [3], m_fb [3], m_fc [3], m_fe [3], m_fg [3];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    // Stand-in adders: combinational, and registered with 2 / 3 cycles of latency.
    // A non-zero mask corrupts the result of the vector it travels with.
    assign live = ({1'b0, a} + {1'b0, b} + {4'd0, cin}) ^ mask;
    always @(posedge clk) begin
        hist[0] <= live;
        for (int i = 1; i < 8; i++) hist[i] <= hist[i-1];
    end
    assign {carry0, sum0} = live;
    assign {carry1, sum1} = hist[1];
    assign {carry2, sum2} = hist[2];

    adder_result_checker #(.WIDTH(4), .LAT(0), .CNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .valid_in(valid_in),
        .a_in(a), .b_in(b), .c_in(cin), .sum(sum0), .carry(carry0),
        .chk_valid(cv0), .mismatch(mm0), .pass_cnt(pc0), .err_cnt(ec0), .err_flag(fl0),
        .first_err_a(fa0), .first_err_b(fb0), .first_err_cin(fc0),
        .first_err_exp(fe0), .first_err_got(fg0));

    adder_result_checker #(.WIDTH(4), .LAT(2), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .valid_in(valid_in),
        .a_in(a), .b_in(b), .c_in(cin), .sum(sum1), .carry(carry1),
        .chk_valid(cv1), .mismatch(mm1), .pass_cnt(pc1), .err_cnt(ec1), .err_flag(fl1),
        .first_err_a(fa1), .first_err_b(fb1), .first_err_cin(fc1),
        .first_err_exp(fe1), .first_err_got(fg1));

    adder_result_checker #(.WIDTH(4), .LAT(3), .CNT_W(4)) u2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .valid_in(valid_in),
        .a_in(a), .b_in(b), .c_in(cin), .sum(sum2), .carry(carry2),
        .chk_valid(cv2), .mismatch(mm2), .pass_cnt(pc2), .err_cnt(ec2), .err_flag(fl2),
        .first_err_a(fa2), .first_err_b(fb2), .first_err_cin(fc2),
        .first_err_exp(fe2), .first_err_got(fg2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int k = 0; k < 3; k++) begin
            m_cv[k] = 0; m_mm[k] = 0; m_pc[k] = 0; m_ec[k] = 0; m_fl[k] = 0;
            m_fa[k] = 0; m_fb[k] = 0; m_fc[k] = 0; m_fe[k] = 0; m_fg[k] = 0;
        end
    endtask

    task automatic compare(input vec_t v);
        int e;
        int g;
        int k;
        e = v.a + v.b + v.cin;
        g = e ^ v.mask;
        k = v.k;
        m_cv[k] = 1;
        if (g == e) begin
            if (m_pc[k] < CMAX[k]) m_pc[k]++;
        end else begin
            m_mm[k] = 1;
            if (m_ec[k] < CMAX[k]) m_ec[k]++;
            if (m_fl[k] == 0) begin
                m_fa[k] = v.a; m_fb[k] = v.b; m_fc[k] = v.cin;
                m_fe[k] = e;   m_fg[k] = g;
            end
            m_fl[k] = 1;
        end
    endtask

    // Advances the model by the clock edge just taken, using the inputs seen at that edge.
    task automatic model_edge();
        vec_t keep[$];
        for (int k = 0; k < 3; k++) begin
            m_cv[k] = 0;
            m_mm[k] = 0;
        end
        if (!rst_n || clear) begin
            model_reset();
        end else begin
            if (valid_in) begin
                for (int k = 0; k < 3; k++)
                    q.push_back('{cyc + LATS[k], k, int'(a), int'(b), int'(cin), int'(mask)});
            end
            foreach (q[i]) begin
                if (q[i].due == cyc) compare(q[i]);
                else keep.push_back(q[i]);
            end
            q = keep;
        end
        cyc++;
    endtask

    task automatic chk_inst(input int k, input logic cv, input logic mm,
                            input logic [15:0] pc, input logic [15:0] ec, input logic fl,
                            input logic [3:0] fa, input logic [3:0] fb, input logic fc,
                            input logic [4:0] fe, input logic [4:0] fg);
        chk($sformatf("u%0d@%0d chk_valid", k, cyc), 32'(cv), m_cv[k]);
        chk($sformatf("u%0d@%0d mismatch", k, cyc), 32'(mm), m_mm[k]);
        chk($sformatf("u%0d@%0d pass_cnt", k, cyc), 32'(pc), m_pc[k]);
        chk($sformatf("u%0d@%0d err_cnt", k, cyc), 32'(ec), m_ec[k]);
        chk($sformatf("u%0d@%0d err_flag", k, cyc), 32'(fl), m_fl[k]);
        chk($sformatf("u%0d@%0d first_err_a", k, cyc), 32'(fa), m_fa[k]);
        chk($sformatf("u%0d@%0d first_err_b", k, cyc), 32'(fb), m_fb[k]);
        chk($sformatf("u%0d@%0d first_err_cin", k, cyc), 32'(fc), m_fc[k]);
        chk($sformatf("u%0d@%0d first_err_exp", k, cyc), 32'(fe), m_fe[k]);
        chk($sformatf("u%0d@%0d first_err_got", k, cyc), 32'(fg), m_fg[k]);
    endtask

    task automatic check_all();
        chk_inst(0, cv0, mm0, pc0, ec0, fl0, fa0, fb0, fc0, fe0, fg0);
        chk_inst(1, cv1, mm1, pc1, ec1, fl1, fa1, fb1, fc1, fe1, fg1);
        chk_inst(2, cv2, mm2, {12'd0, pc2}, {12'd0, ec2}, fl2, fa2, fb2, fc2, fe2, fg2);
    endtask

    task automatic step(input logic v, input logic [3:0] aa, input logic [3:0] bb,
                        input logic cc, input logic [4:0] mk, input logic clr);
        valid_in = v; a = aa; b = bb; cin = cc; mask = mk; clear = clr;
        @(posedge clk);
        #1;
        model_edge();
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 4'd0, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        logic [7:0] iv;
        rst_n = 1'b0; clear = 1'b0; valid_in = 1'b0;
        a = '0; b = '0; cin = 1'b0; mask = '0;
        cyc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // T1: 3+4+1 = 8 passes, visible one cycle later
        step(1'b1, 4'd3, 4'd4, 1'b1, 5'd0, 1'b0);
        chk("T1 chk_valid", 32'(cv0), 32'd1);
        chk("T1 pass_cnt", 32'(pc0), 32'd1);
        idle(4);

        // T2: 15+15+1 passes, then carry/sum 1E instead of 1F
        step(1'b1, 4'd15, 4'd15, 1'b1, 5'd0, 1'b0);
        step(1'b1, 4'd15, 4'd15, 1'b1, 5'h01, 1'b0);
        chk("T2 first_err_exp", 32'(fe0), 32'h1F);
        chk("T2 first_err_got", 32'(fg0), 32'h1E);
        idle(4);

        // T4: two failures, snapshot keeps the first; clear; clear coincident with compare
        step(1'b0, 4'd0, 4'd0, 1'b0, 5'd0, 1'b1);
        step(1'b1, 4'd1, 4'd1, 1'b0, 5'h01, 1'b0);
        step(1'b1, 4'd2, 4'd2, 1'b0, 5'h02, 1'b0);
        idle(4);
        chk("T4 err_cnt", 32'(ec2), 32'd2);
        chk("T4 snapshot a", 32'(fa2), 32'd1);
        step(1'b0, 4'd0, 4'd0, 1'b0, 5'd0, 1'b1);
        step(1'b1, 4'd5, 4'd5, 1'b0, 5'd0, 1'b1);
        step(1'b1, 4'd6, 4'd6, 1'b0, 5'd0, 1'b0);
        step(1'b0, 4'd0, 4'd0, 1'b0, 5'd0, 1'b0);
        step(1'b0, 4'd0, 4'd0, 1'b0, 5'd0, 1'b1);
        idle(4);

        // T3/T5: 256 back-to-back vectors, all a/b combinations, cin toggling
        step(1'b0, 4'd0, 4'd0, 1'b0, 5'd0, 1'b1);
        for (int i = 0; i < 256; i++) begin
            iv = 8'(i);
            step(1'b1, iv[3:0], iv[7:4], iv[0], 5'd0, 1'b0);
        end
        idle(4);
        chk("T3 pass_cnt", 32'(pc1), 32'd256);
        chk("T5 pass_cnt saturated", 32'(pc2), 32'd15);

        // Randomized traffic with occasional corruption and clears
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom), 1'($urandom),
                 ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
                 $urandom_range(0, 39) == 0);
        end
        idle(4);

        // T6: reset with vectors in flight
        step(1'b1, 4'd7, 4'd8, 1'b0, 5'd0, 1'b0);
        step(1'b1, 4'd9, 4'd2, 1'b1, 5'd0, 1'b0);
        step(1'b1, 4'd4, 4'd4, 1'b1, 5'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        step(1'b0, 4'd0, 4'd0, 1'b0, 5'd0, 1'b0);
        rst_n = 1'b1;
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
